// File: rtl/mtf_pkg.sv
// Shared definitions for the time-multiplexed MTF neuron array.
// Contents:
//   mtf_state_e   - step sequencer state encoding (IDLE -> RUN -> DONE)
//   CALC_W/calc_t - wide signed type used for exact intermediate arithmetic
//   one_of        - fixed-point ONE for a given number of fractional bits
//   max_of/min_of - two's-complement limits of a given width
//   clamp/sat     - bound a wide value to a range / to a width's limits
package mtf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mtf_state_e;

  // Wide enough for every intermediate sum in the neuron update
  // (DATA_W + 4 bits), so no intermediate result can wrap.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t one_of(input int frac_w);
    return calc_t'(1) <<< frac_w;
  endfunction

  function automatic calc_t max_of(input int w);
    return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
  endfunction

  function automatic calc_t min_of(input int w);
    return -(calc_t'(1) <<< (w - 1));
  endfunction

  function automatic calc_t clamp(input calc_t x, input calc_t lo, input calc_t hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic calc_t sat(input calc_t x, input int w);
    return clamp(x, min_of(w), max_of(w));
  endfunction

endpackage

// File: rtl/mtf_pwl_current.sv
// Piecewise-linear conductance current for one MTF feedback branch.
//   current = sat((alpha * clamp(x_state - delta, -ONE, +ONE)) >>> FRAC_W)
// Ports:
//   x_state - filtered state variable (v, vs or vus), signed DATA_W
//   delta   - branch offset, signed DATA_W
//   alpha   - branch gain, signed DATA_W
//   current - branch current saturated to DATA_W
module mtf_pwl_current
  import mtf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] x_state,
  input  logic signed [DATA_W-1:0] delta,
  input  logic signed [DATA_W-1:0] alpha,
  output logic signed [DATA_W-1:0] current
);

  calc_t                      x_raw;
  calc_t                      x_clamped;
  logic signed [2*DATA_W-1:0] prod;

  // NOTE: every variable driven here gets a value on every pass through
  // the block; a path that leaves one unassigned infers a latch.
  always_comb begin
    x_raw     = calc_t'(x_state) - calc_t'(delta);
    x_clamped = clamp(x_raw, -one_of(FRAC_W), one_of(FRAC_W));
    // The clamped operand always fits, so the 2*DATA_W product is exact.
    prod      = (2*DATA_W)'(alpha) * (2*DATA_W)'(x_clamped);
    current   = DATA_W'(sat(calc_t'(prod >>> FRAC_W), DATA_W));
  end

endmodule

// File: rtl/mtf_neuron_array.sv
// Array of N_NEURONS mixed-feedback (MTF) neurons sharing one datapath.
// A step visits neurons 0..N_NEURONS-1, one per cycle, updating v, vs and
// vus from their pre-step values and the configuration latched at accept.
// Ports:
//   clk, reset_n          - rising-edge clock, async active-low reset
//   step_valid/step_ready - request/accept one step over all neurons
//   i_ext_flat            - external current, neuron k at [k*DATA_W +: DATA_W]
//   afn..ausp, dfn..dusp  - shared branch gains and offsets
//   v_out, v_idx, v_valid - updated voltage of one neuron per cycle
//   step_done             - one-cycle pulse after the last neuron's v_valid
module mtf_neuron_array
  import mtf_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int SHIFT_S   = 7,
  parameter int SHIFT_US  = 12,
  parameter int DT_SHIFT  = 4,
  localparam int IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          step_valid,
  output logic                          step_ready,
  input  logic [N_NEURONS*DATA_W-1:0]   i_ext_flat,
  input  logic signed [DATA_W-1:0]      afn,
  input  logic signed [DATA_W-1:0]      asp,
  input  logic signed [DATA_W-1:0]      asn,
  input  logic signed [DATA_W-1:0]      ausp,
  input  logic signed [DATA_W-1:0]      dfn,
  input  logic signed [DATA_W-1:0]      dsp,
  input  logic signed [DATA_W-1:0]      dsn,
  input  logic signed [DATA_W-1:0]      dusp,
  output logic signed [DATA_W-1:0]      v_out,
  output logic [IDX_W-1:0]              v_idx,
  output logic                          v_valid,
  output logic                          step_done
);

  typedef struct packed {
    logic signed [DATA_W-1:0] afn, asp, asn, ausp;
    logic signed [DATA_W-1:0] dfn, dsp, dsn, dusp;
  } cfg_t;

  mtf_state_e               state;
  logic [IDX_W-1:0]         idx;
  cfg_t                     cfg_q;
  logic signed [DATA_W-1:0] i_ext_q [N_NEURONS];
  logic signed [DATA_W-1:0] v_mem   [N_NEURONS];
  logic signed [DATA_W-1:0] vs_mem  [N_NEURONS];
  logic signed [DATA_W-1:0] vus_mem [N_NEURONS];

  logic signed [DATA_W-1:0] v_cur, vs_cur, vus_cur, ie_cur;
  logic signed [DATA_W-1:0] i_fn, i_sp, i_sn, i_usp;
  logic signed [DATA_W+1:0] i_sum;
  logic signed [DATA_W-1:0] v_new, vs_new, vus_new;

  assign step_ready = (state == ST_IDLE);

  // Pre-step values of the neuron currently being processed.
  assign v_cur   = v_mem[idx];
  assign vs_cur  = vs_mem[idx];
  assign vus_cur = vus_mem[idx];
  assign ie_cur  = i_ext_q[idx];

  mtf_pwl_current #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_fn (
    .x_state(v_cur),   .delta(cfg_q.dfn),  .alpha(cfg_q.afn),  .current(i_fn));
  mtf_pwl_current #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_sp (
    .x_state(vs_cur),  .delta(cfg_q.dsp),  .alpha(cfg_q.asp),  .current(i_sp));
  mtf_pwl_current #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_sn (
    .x_state(vs_cur),  .delta(cfg_q.dsn),  .alpha(cfg_q.asn),  .current(i_sn));
  mtf_pwl_current #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_usp (
    .x_state(vus_cur), .delta(cfg_q.dusp), .alpha(cfg_q.ausp), .current(i_usp));

  always_comb begin
    i_sum   = (DATA_W+2)'(i_fn) + (DATA_W+2)'(i_sp)
            + (DATA_W+2)'(i_sn) + (DATA_W+2)'(i_usp);
    v_new   = DATA_W'(sat(calc_t'(v_cur) + ((calc_t'(ie_cur) - calc_t'(v_cur)
                          - calc_t'(i_sum)) >>> DT_SHIFT), DATA_W));
    vs_new  = DATA_W'(sat(calc_t'(vs_cur)
                          + ((calc_t'(v_cur) - calc_t'(vs_cur)) >>> SHIFT_S), DATA_W));
    vus_new = DATA_W'(sat(calc_t'(vus_cur)
                          + ((calc_t'(v_cur) - calc_t'(vus_cur)) >>> SHIFT_US), DATA_W));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cfg_q     <= '0;
      v_out     <= '0;
      v_idx     <= '0;
      v_valid   <= 1'b0;
      step_done <= 1'b0;
      // NOTE: the neuron state arrays are register files, not RAM macros,
      // because the whole array must read back as zero right after reset.
      for (int k = 0; k < N_NEURONS; k++) begin
        i_ext_q[k] <= '0;
        v_mem[k]   <= '0;
        vs_mem[k]  <= '0;
        vus_mem[k] <= '0;
      end
    end else begin
      v_valid   <= 1'b0;
      step_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (step_valid) begin
            cfg_q <= '{afn: afn, asp: asp, asn: asn, ausp: ausp,
                       dfn: dfn, dsp: dsp, dsn: dsn, dusp: dusp};
            for (int k = 0; k < N_NEURONS; k++)
              i_ext_q[k] <= i_ext_flat[k*DATA_W +: DATA_W];
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          v_mem[idx]   <= v_new;
          vs_mem[idx]  <= vs_new;
          vus_mem[idx] <= vus_new;
          v_out        <= v_new;
          v_idx        <= idx;
          v_valid      <= 1'b1;
          if (idx == IDX_W'(N_NEURONS - 1)) state <= ST_DONE;
          else                              idx   <= idx + 1'b1;
        end
        ST_DONE: begin
          step_done <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtf_neuron_array.sv
// Self-checking bench for mtf_neuron_array (N_NEURONS=4, DATA_W=16).
// A fixed vector table and hand-written sequences cover the known-answer
// and corner cases; random configurations are checked against a
// behavioural model built from floor division and plain integer limits.
module tb_mtf_neuron_array;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int SS  = 7;
  localparam int SUS = 12;
  localparam int DTS = 4;
  localparam int IW  = 2;
  localparam longint ONE  = 256;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 step_valid = 1'b0;
  logic                 step_ready;
  logic [N*DW-1:0]      i_ext_flat = '0;
  logic signed [DW-1:0] afn = '0, asp = '0, asn = '0, ausp = '0;
  logic signed [DW-1:0] dfn = '0, dsp = '0, dsn = '0, dusp = '0;
  logic signed [DW-1:0] v_out;
  logic [IW-1:0]        v_idx;
  logic                 v_valid;
  logic                 step_done;

  always #5 clk = ~clk;

  mtf_neuron_array #(
    .N_NEURONS(N), .DATA_W(DW), .FRAC_W(FW),
    .SHIFT_S(SS), .SHIFT_US(SUS), .DT_SHIFT(DTS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .step_valid(step_valid), .step_ready(step_ready),
    .i_ext_flat(i_ext_flat),
    .afn(afn), .asp(asp), .asn(asn), .ausp(ausp),
    .dfn(dfn), .dsp(dsp), .dsn(dsn), .dusp(dusp),
    .v_out(v_out), .v_idx(v_idx), .v_valid(v_valid), .step_done(step_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_v[N], m_vs[N], m_vus[N];
  longint exp_v[N];
  longint last_v0;

  function automatic longint lim(input longint x, input longint lo, input longint hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  // Floor division by 2^s (arithmetic right shift semantics).
  function automatic longint shr(input longint x, input int s);
    longint p = longint'(1) << s;
    if (x >= 0) return x / p;
    return -((-x + p - 1) / p);
  endfunction

  function automatic longint pwl(input longint st, input longint d, input longint a);
    return lim(shr(a * lim(st - d, -ONE, ONE), FW), MINV, MAXV);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_v[k] = 0; m_vs[k] = 0; m_vus[k] = 0; exp_v[k] = 0;
    end
  endfunction

  // Called at the accepting edge: reads the stimulus the bench is driving.
  function automatic void model_step();
    for (int k = 0; k < N; k++) begin
      longint v   = m_v[k];
      longint vs  = m_vs[k];
      longint vus = m_vus[k];
      longint ie  = longint'($signed(i_ext_flat[k*DW +: DW]));
      longint isum = pwl(v, dfn, afn) + pwl(vs, dsp, asp)
                   + pwl(vs, dsn, asn) + pwl(vus, dusp, ausp);
      m_v[k]   = lim(v + shr(ie - v - isum, DTS), MINV, MAXV);
      m_vs[k]  = lim(vs + shr(v - vs, SS), MINV, MAXV);
      m_vus[k] = lim(vus + shr(v - vus, SUS), MINV, MAXV);
      exp_v[k] = m_v[k];
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic signed [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  task automatic set_cfg(input longint a_fn, input longint d_fn, input longint ie0);
    afn = DW'(a_fn); dfn = DW'(d_fn);
    asp = '0; asn = '0; ausp = '0; dsp = '0; dsn = '0; dusp = '0;
    i_ext_flat = '0;
    i_ext_flat[0 +: DW] = DW'(ie0);
  endtask

  task automatic randomize_inputs();
    afn = rnd(); asp = rnd(); asn = rnd(); ausp = rnd();
    dfn = rnd(); dsp = rnd(); dsn = rnd(); dusp = rnd();
    for (int k = 0; k < N; k++) i_ext_flat[k*DW +: DW] = rnd();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    step_valid = 1'b0;
    #1;
    check("reset v_valid", v_valid, 0);
    check("reset step_done", step_done, 0);
    check("reset v_out", v_out, 0);
    check("reset v_idx", v_idx, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("reset step_ready", step_ready, 1);
    model_reset();
  endtask

  // One step: accept, collect v_valid beats, check order, values and done.
  // With hold set, step_valid stays high through RUN, inputs are scrambled
  // mid-step, and step_valid drops only once the last neuron appears.
  task automatic run_step(input string tag, input bit hold);
    int  seen = 0;
    int  last = -10;
    int  cyc = 0;
    bit  done = 1'b0;
    @(posedge clk); #1;
    check({tag, " ready before"}, step_ready, 1);
    step_valid = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    if (!hold) step_valid = 1'b0;
    check({tag, " ready during"}, step_ready, 0);
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (hold && cyc == 2) randomize_inputs();
      if (v_valid) begin
        if (seen < N) begin
          check({tag, " v_idx"}, v_idx, seen);
          check({tag, " v_out"}, v_out, exp_v[seen]);
          check({tag, " v_valid cycle"}, cyc, seen + 1);
          if (seen == 0) last_v0 = longint'(v_out);
        end else begin
          check({tag, " extra v_valid"}, seen, N - 1);
        end
        if (hold && v_idx == IW'(N - 1)) step_valid = 1'b0;
        seen++;
        last = cyc;
      end
      if (step_done) begin
        done = 1'b1;
        check({tag, " step_done cycle"}, cyc, last + 1);
      end
    end
    check({tag, " v_valid count"}, seen, N);
    check({tag, " step_done seen"}, done, 1);
    step_valid = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int beats = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (v_valid || step_done) beats++;
    end
    check({tag, " quiet"}, beats, 0);
    check({tag, " ready idle"}, step_ready, 1);
  endtask

  // ---------------- known-answer table ----------------
  typedef struct {
    string  name;
    longint ie0;
    longint a_fn;
    longint d_fn;
    int     steps;
    longint exp_v0;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint prev;
    int     beats;
    int     cyc;

    vecs[0] = '{"zero step",     0,   0,   0, 1,  0};
    vecs[1] = '{"iext 1 step",   256, 0,   0, 1, 16};
    vecs[2] = '{"iext 2 steps",  256, 0,   0, 2, 31};
    vecs[3] = '{"afn 1 step",    256, 256, 0, 1, 16};
    vecs[4] = '{"afn 2 steps",   256, 256, 0, 2, 30};

    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_reset();
      set_cfg(vecs[i].a_fn, vecs[i].d_fn, vecs[i].ie0);
      for (int s = 0; s < vecs[i].steps; s++) run_step(vecs[i].name, 1'b0);
      check({vecs[i].name, " v0"}, last_v0, vecs[i].exp_v0);
    end

    // Random configurations against the model, state carried across steps.
    do_reset();
    for (int s = 0; s < 25; s++) begin
      randomize_inputs();
      run_step("random", 1'b0);
    end

    // Large drive: voltage must rise monotonically and never wrap.
    do_reset();
    set_cfg(0, 0, 32767);
    prev = 0;
    for (int s = 0; s < 200; s++) begin
      run_step("sat", 1'b0);
      if (last_v0 < prev || last_v0 < 0)
        check("sat monotonic", last_v0, prev);
      prev = last_v0;
    end
    check("sat not negative", (prev > 0) ? 1 : 0, 1);
    check("sat final", prev, m_v[0]);

    // step_valid held through RUN with inputs changed mid-step.
    do_reset();
    set_cfg(0, 0, 256);
    for (int k = 1; k < N; k++) i_ext_flat[k*DW +: DW] = DW'(100 * k);
    run_step("held valid", 1'b1);
    check("held valid v0", last_v0, 16);
    expect_quiet("held valid", 8);

    // Reset asserted while neuron 2 is being presented.
    do_reset();
    randomize_inputs();
    @(posedge clk); #1;
    step_valid = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    cyc = 0;
    while (!(v_valid && v_idx == IW'(2)) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort reached idx2", (v_valid && v_idx == IW'(2)) ? 1 : 0, 1);
    reset_n = 1'b0;
    #1;
    check("abort v_valid low", v_valid, 0);
    check("abort v_out cleared", v_out, 0);
    #2 reset_n = 1'b1;
    model_reset();
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (v_valid || step_done) beats++;
    end
    check("abort no further output", beats, 0);
    set_cfg(0, 0, 0);
    run_step("after abort", 1'b0);
    check("after abort v0", last_v0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtf_neuron_array.md
MTF_NEURON_ARRAY -- requirements
Module: mtf_neuron_array

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: neurons time-multiplexed on one datapath, range 1..256.
REQ-002 SHALL have parameter DATA_W, default 16: signed two's-complement width of all voltages, currents, alphas and deltas.
REQ-003 SHALL have parameter FRAC_W, default 8: fractional bits; ONE = 2^FRAC_W.
REQ-004 SHALL have parameters SHIFT_S (default 7), SHIFT_US (default 12), DT_SHIFT (default 4): slow/ultraslow filter and integration shifts.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port step_valid, input, 1: request one integration step over all neurons.
REQ-008 SHALL have port step_ready, output, 1: high when idle and a step can be accepted.
REQ-009 SHALL have port i_ext_flat, input, N_NEURONS*DATA_W: external current, neuron k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have ports afn, asp, asn, ausp, dfn, dsp, dsn, dusp, each input, DATA_W, signed: shared conductance gains and offsets.
REQ-011 SHALL have port v_out, output, DATA_W: updated membrane voltage of neuron v_idx.
REQ-012 SHALL have port v_idx, output, max(1,clog2(N_NEURONS)): neuron index of v_out.
REQ-013 SHALL have port v_valid, output, 1: v_out/v_idx valid this cycle.
REQ-014 SHALL have port step_done, output, 1: one-cycle pulse after the last neuron of a step.

Function
REQ-015 SHALL keep per-neuron state v, vs, vus (DATA_W signed each) in internal storage of depth N_NEURONS.
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; IDLE->RUN when step_valid && step_ready; RUN advances neuron index 0..N_NEURONS-1, one per cycle; after index N_NEURONS-1, RUN->DONE; DONE->IDLE after one cycle.
REQ-017 SHALL assert step_ready only in IDLE; step_valid outside IDLE SHALL be ignored, not queued.
REQ-018 SHALL latch i_ext_flat and all eight alpha/delta inputs at step acceptance; input changes during RUN SHALL NOT affect the current step.
REQ-019 SHALL compute, per neuron from pre-step values: x_fn = v-dfn, x_sp = vs-dsp, x_sn = vs-dsn, x_usp = vus-dusp, each clamped to [-ONE, +ONE].
REQ-020 SHALL compute each I_x = (alpha_x * clamped x_x) >>> FRAC_W with full 2*DATA_W product, then saturate to DATA_W.
REQ-021 SHALL compute Isum = I_fn + I_sp + I_sn + I_usp in DATA_W+2 bits, no wrap.
REQ-022 SHALL update v_new = sat(v + ((i_ext - v - Isum) >>> DT_SHIFT)), arithmetic shifts and saturation to DATA_W limits.
REQ-023 SHALL update vs_new = sat(vs + ((v - vs) >>> SHIFT_S)) and vus_new = sat(vus + ((v - vus) >>> SHIFT_US)), using pre-step v.
REQ-024 SHALL write back v_new, vs_new, vus_new and present v_out = v_new, v_idx = k, v_valid = 1 in the cycle after neuron k is processed (latency 1 per neuron).
REQ-025 SHALL assert step_done exactly once per step, one cycle after v_valid for index N_NEURONS-1; N_NEURONS=1 SHALL work with one v_valid then step_done.

Reset
REQ-026 SHALL, on reset_n low, immediately clear all v, vs, vus, latched config, FSM to IDLE, v_out=0, v_idx=0, v_valid=0, step_done=0, step_ready=1 after release.
REQ-027 SHALL abort any step in progress on reset; no further v_valid/step_done from the aborted step.

Structure
REQ-028 SHALL place state encoding, ONE and saturate/clamp width constants in shared package mtf_pkg.
REQ-029 SHALL implement clamp-multiply-saturate as sub-module mtf_pwl_current, instantiated four times.

Verification (N_NEURONS=4, DATA_W=16, FRAC_W=8, DT_SHIFT=4)
REQ-030 Reset, all alphas 0, i_ext all 0, one step -> v_valid for idx 0,1,2,3 on consecutive cycles with v_out=0, step_done one cycle after idx 3.
REQ-031 Alphas 0, i_ext[0]=256, step -> idx0 v_out=16; second step -> 16+((256-16)>>>4)=31.
REQ-032 afn=256, dfn=0, others 0, i_ext[0]=256, two steps -> 16 then 30 (I_fn=16).
REQ-033 i_ext[0]=32767, alphas 0, 200 steps -> v_out monotonic, never exceeds 32767, never wraps negative.
REQ-034 step_valid held high through RUN, i_ext changed mid-step -> step_ready=0, exactly one step runs, values use latched i_ext.
REQ-035 reset_n pulsed low at idx 2 of a step -> no further v_valid/step_done; next step from zero state gives REQ-030 outputs.
